systolic_matmul_engine: RTL
===========================

// Module: systolic_matmul_engine
// PURPOSE
//  Parametrised output-stationary NxN systolic matrix-multiply engine: computes C = A x B.
//  A is streamed in column by column and B row by row, over K beats.
//  Unlike the fixed 2x2 manager, it:
//   - skews its own inputs internally,
//   - runs a start/feed/flush/readout FSM,
//   - uses valid/ready handshakes on both the input and output sides.
//  Sits between the operand buffers and the result writeback path of the TPU datapath.
// PARAMETERS
//  N          4   array dimension (NxN PEs); N >= 2
//  OP_WIDTH   8   signed two's-complement operand width
//  ACC_WIDTH  32  signed accumulator width; must be >= 2*OP_WIDTH
//  K_WIDTH    16  width of the reduction-length field
// PORTS
//  clk          in   1                single clock, rising edge
//  reset        in   1                synchronous, active-high
//  start        in   1                begin a job; sampled only in IDLE
//  k_len        in   K_WIDTH          number of A-column/B-row beats; latched on start
//  in_valid     in   1                a_col/b_row beat valid
//  in_ready     out  1                engine accepts a beat
//  a_col        in   N*OP_WIDTH       A column k; element i (row i) at [i*OP_WIDTH +: OP_WIDTH]
//  b_row        in   N*OP_WIDTH       B row k; element j (column j) at [j*OP_WIDTH +: OP_WIDTH]
//  out_valid    out  1                out_row holds a result row
//  out_ready    in   1                consumer accepts the row
//  out_row      out  N*ACC_WIDTH      C row out_row_idx; element j at [j*ACC_WIDTH +: ACC_WIDTH]
//  out_row_idx  out  $clog2(N)        index of the row currently presented
//  busy         out  1                high in every state except IDLE
// BEHAVIOUR
//  Reset (synchronous, active-high):
//   - FSM goes to IDLE; all outputs are 0.
//   - All skew registers, PE pipeline registers and accumulators are cleared.
//   - Reset overrides any job in flight. A partial result is never emitted.
//  FSM states: IDLE, FEED, FLUSH, OUT.
//  IDLE:
//   - start=1 latches k_len, clears all accumulators, and sets the beat counter to 0.
//   - Next state: FEED if k_len != 0; OUT if k_len == 0 (all-zero result).
//  FEED:
//   - in_ready = 1.
//   - A beat is accepted when in_valid && in_ready.
//   - The array advances every cycle. A cycle without an accepted beat injects zeros for A and B (bubble).
//   - Next state: FLUSH after the k_len-th accepted beat.
//   - start is ignored in this state.
//  FLUSH:
//   - in_ready = 0. Zeros are injected for exactly 2*N-1 cycles, then the FSM goes to OUT.
//  Skew:
//   - a_col element i is delayed by i cycles before entering PE(i,0).
//   - b_row element j is delayed by j cycles before entering PE(0,j).
//  PE(i,j), every cycle:
//   - acc += a*b (signed, sign-extended to ACC_WIDTH).
//   - a is registered and forwarded to PE(i,j+1); b is registered and forwarded to PE(i+1,j).
//  Accumulation wraps modulo 2^ACC_WIDTH unless SATURATE_EN is defined.
//  OUT:
//   - Rows 0..N-1 are presented in order; out_valid = 1.
//   - out_row and out_row_idx stay stable while out_valid && !out_ready.
//   - A row advances on out_valid && out_ready.
//   - After the handshake on row N-1: IDLE on the next cycle, with out_valid = 0 and busy = 0.
//  Latency: first out_valid arrives 2*N cycles after the last accepted beat (2*N-1 flush cycles + 1).
//  The earliest restart is a start in the first IDLE cycle.
// CONFIGURATION
//  SATURATE_EN:
//   - Defined: each PE add saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
//   - Once saturated, an accumulator stays clamped only until an opposite-sign product brings it back in range.
//  Undefined: plain two's-complement wrap-around. Port list and timing are identical in both builds.
// TESTING
//  1. N=4, A=I, B=[1..16] row-major, k_len=4, in_valid held high -> rows out = B exactly, idx 0..3, out_valid 8 cycles after the last beat.
//  2. Same job with in_valid low on beats 1 and 3 for 2 cycles each -> identical C; FEED lasts 8 cycles.
//  3. out_ready toggled 1-0-0-1 during OUT -> each row is held stable while stalled; exactly 4 handshakes, then busy=0.
//  4. start with k_len=0 -> OUT directly, 4 all-zero rows, no in_ready pulse.
//  5. reset asserted during FLUSH of a job, then a new job with A=B=all-2, k_len=3 -> every C entry = 12 (no residue from the aborted job).
//  6. ACC_WIDTH=16, A=B=all -128, k_len=3 (sum 49152):
//     - SATURATE_EN defined: every C = 32767.
//     - Undefined: every C = -16384.

Source files
------------

// File: rtl/systolic_matmul_engine.sv
// systolic_matmul_engine: output-stationary NxN systolic C=AxB engine (A by column, B by row, K beats) with internal input skew and an IDLE/FEED/FLUSH/OUT FSM; ports clk, reset (sync, active-high), start/k_len, in_valid/in_ready with a_col/b_row, out_valid/out_ready with out_row/out_row_idx, busy; define SATURATE_EN for saturating accumulators (default wraps)
module systolic_matmul_engine #(
  parameter int N = 4,
  parameter int OP_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int K_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [K_WIDTH-1:0]     k_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*OP_WIDTH-1:0]  a_col,
  input  logic [N*OP_WIDTH-1:0]  b_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*ACC_WIDTH-1:0] out_row,
  output logic [$clog2(N)-1:0]   out_row_idx,
  output logic                   busy
);
  localparam int RW = $clog2(N);
  localparam int FW = $clog2(2*N);
  typedef enum logic [1:0] {IDLE, FEED, FLUSH, OUT} state_t;
  typedef logic signed [OP_WIDTH-1:0] op_t;
  typedef logic signed [ACC_WIDTH-1:0] acc_t;
  state_t r_state, w_nxt;
  logic [K_WIDTH-1:0] r_k, r_cnt;
  logic [FW-1:0] r_fl;
  logic [RW-1:0] r_row;
  logic w_acc, w_clr;
  op_t w_a_in [N], w_b_in [N], w_a [N][N], w_b [N][N];
  op_t r_sa [N][N-1], r_sb [N][N-1], r_a [N][N-1], r_b [N-1][N];
  acc_t r_acc [N][N];
  function automatic acc_t f_mac(input acc_t x, input op_t a, input op_t b);
    logic signed [2*OP_WIDTH-1:0] p;
`ifdef SATURATE_EN
    logic signed [ACC_WIDTH:0] s;
    p = a * b;
    s = (ACC_WIDTH+1)'(x) + (ACC_WIDTH+1)'(p);
    return s[ACC_WIDTH] != s[ACC_WIDTH-1] ? {s[ACC_WIDTH], {(ACC_WIDTH-1){~s[ACC_WIDTH]}}} : s[ACC_WIDTH-1:0];
`else
    p = a * b;
    return x + ACC_WIDTH'(p);
`endif
  endfunction
  assign in_ready = r_state == FEED;
  assign out_valid = r_state == OUT;
  assign busy = r_state != IDLE;
  assign out_row_idx = r_row;
  assign w_acc = in_ready && in_valid;
  assign w_clr = r_state == IDLE && start;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = start ? (k_len == '0 ? OUT : FEED) : IDLE;
      FEED:    w_nxt = w_acc && r_cnt == r_k - K_WIDTH'(1) ? FLUSH : FEED;
      FLUSH:   w_nxt = r_fl == FW'(2*N-2) ? OUT : FLUSH;
      default: w_nxt = out_ready && r_row == RW'(N-1) ? IDLE : OUT;
    endcase
  end
  always_comb begin
    out_row = '0;
    for (int i = 0; i < N; i++) begin
      w_a_in[i] = w_acc ? a_col[i*OP_WIDTH +: OP_WIDTH] : '0;
      w_b_in[i] = w_acc ? b_row[i*OP_WIDTH +: OP_WIDTH] : '0;
    end
    w_a[0][0] = w_a_in[0];
    w_b[0][0] = w_b_in[0];
    for (int i = 1; i < N; i++) begin
      w_a[i][0] = r_sa[i][i-1];
      w_b[0][i] = r_sb[i][i-1];
    end
    for (int i = 0; i < N; i++)
      for (int j = 1; j < N; j++) begin
        w_a[i][j] = r_a[i][j-1];
        w_b[j][i] = r_b[j-1][i];
      end
    for (int j = 0; j < N; j++)
      out_row[j*ACC_WIDTH +: ACC_WIDTH] = out_valid ? r_acc[r_row][j] : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_k <= '0;
      r_cnt <= '0;
      r_fl <= '0;
      r_row <= '0;
    end else begin
      r_state <= w_nxt;
      r_k <= w_clr ? k_len : r_k;
      r_cnt <= w_clr ? '0 : r_cnt + K_WIDTH'(w_acc);
      r_fl <= r_state == FLUSH ? r_fl + FW'(1) : '0;
      r_row <= out_valid && out_ready ? (r_row == RW'(N-1) ? '0 : r_row + RW'(1)) : r_row;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) r_acc[i][j] <= '0;
        for (int j = 0; j < N-1; j++) begin
          r_sa[i][j] <= '0;
          r_sb[i][j] <= '0;
          r_a[i][j] <= '0;
          r_b[j][i] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        r_sa[i][0] <= w_a_in[i];
        r_sb[i][0] <= w_b_in[i];
        for (int j = 1; j < N-1; j++) begin
          r_sa[i][j] <= r_sa[i][j-1];
          r_sb[i][j] <= r_sb[i][j-1];
        end
        for (int j = 0; j < N-1; j++) begin
          r_a[i][j] <= w_a[i][j];
          r_b[j][i] <= w_b[j][i];
        end
        for (int j = 0; j < N; j++)
          r_acc[i][j] <= w_clr ? '0 : f_mac(r_acc[i][j], w_a[i][j], w_b[i][j]);
      end
    end
  end
endmodule
